// File: rtl/y86_pkg.sv
// Shared Y86-64 encoding constants, encoder state type and the instruction length table.
package y86_pkg;

  localparam logic [3:0] ICODE_HALT   = 4'h0;
  localparam logic [3:0] ICODE_NOP    = 4'h1;
  localparam logic [3:0] ICODE_CMOVXX = 4'h2;
  localparam logic [3:0] ICODE_IRMOVQ = 4'h3;
  localparam logic [3:0] ICODE_RMMOVQ = 4'h4;
  localparam logic [3:0] ICODE_MRMOVQ = 4'h5;
  localparam logic [3:0] ICODE_OPQ    = 4'h6;
  localparam logic [3:0] ICODE_JXX    = 4'h7;
  localparam logic [3:0] ICODE_CALL   = 4'h8;
  localparam logic [3:0] ICODE_RET    = 4'h9;
  localparam logic [3:0] ICODE_PUSHQ  = 4'hA;
  localparam logic [3:0] ICODE_POPQ   = 4'hB;

  localparam logic [3:0] IFUN_MAX_CMOV = 4'd6;
  localparam logic [3:0] IFUN_MAX_OPQ  = 4'd3;
  localparam logic [3:0] IFUN_MAX_JXX  = 4'd6;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_EMIT = 1'b1
  } state_t;

  // Encoded length in bytes; 0 marks an illegal icode/ifun combination.
  function automatic logic [3:0] instr_len(input logic [3:0] icode, input logic [3:0] ifun);
    logic [3:0] len;
    len = 4'd0;
    case (icode)
      ICODE_HALT, ICODE_NOP, ICODE_RET:
        len = (ifun == 4'd0) ? 4'd1 : 4'd0;
      ICODE_CMOVXX:
        len = (ifun <= IFUN_MAX_CMOV) ? 4'd2 : 4'd0;
      ICODE_OPQ:
        len = (ifun <= IFUN_MAX_OPQ) ? 4'd2 : 4'd0;
      ICODE_PUSHQ, ICODE_POPQ:
        len = (ifun == 4'd0) ? 4'd2 : 4'd0;
      ICODE_IRMOVQ, ICODE_RMMOVQ, ICODE_MRMOVQ:
        len = (ifun == 4'd0) ? 4'd10 : 4'd0;
      ICODE_JXX:
        len = (ifun <= IFUN_MAX_JXX) ? 4'd9 : 4'd0;
      ICODE_CALL:
        len = (ifun == 4'd0) ? 4'd9 : 4'd0;
      default:
        len = 4'd0;
    endcase
    return len;
  endfunction

endpackage

// File: rtl/y86_instr_len.sv
// Combinational decode of icode/ifun into legality, field presence and byte length.
module y86_instr_len
  import y86_pkg::*;
(
  input  logic [3:0] icode,
  input  logic [3:0] ifun,
  output logic       legal,
  output logic       has_regids,
  output logic       has_valc,
  output logic [3:0] len
);

  logic [3:0] len_raw;

  always_comb begin
    len_raw    = instr_len(icode, ifun);
    len        = len_raw;
    legal      = (len_raw != 4'd0);
    // Only the 2- and 10-byte forms carry the rA/rB byte; 9 and 10 carry valC.
    has_regids = (len_raw == 4'd2) || (len_raw == 4'd10);
    has_valc   = (len_raw == 4'd9) || (len_raw == 4'd10);
  end

endmodule

// File: rtl/y86_instr_encoder.sv
// Serialises one Y86-64 instruction per accept into a byte stream written at an auto-advancing PC.
module y86_instr_encoder
  import y86_pkg::*;
#(
  parameter int                ADDR_W     = 64,
  parameter logic [ADDR_W-1:0] START_ADDR = '0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              set_pc,
  input  logic [ADDR_W-1:0] new_pc,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [3:0]        icode,
  input  logic [3:0]        ifun,
  input  logic [3:0]        rA,
  input  logic [3:0]        rB,
  input  logic [63:0]       valC,
  output logic              byte_valid,
  input  logic              byte_ready,
  output logic [ADDR_W-1:0] byte_addr,
  output logic [7:0]        byte_data,
  output logic              byte_last,
  output logic [ADDR_W-1:0] pc,
  output logic              enc_err
);

  state_t      state;
  logic        legal;
  logic        has_regids;
  logic        has_valc;
  logic [3:0]  len;
  logic        accept;
  logic [3:0]  idx_q;
  logic [3:0]  idx_nxt;

  logic [3:0]  icode_q;
  logic [3:0]  ifun_q;
  logic [3:0]  ra_q;
  logic [3:0]  rb_q;
  logic [63:0] valc_q;
  logic [3:0]  len_q;
  logic        has_regids_q;

  y86_instr_len u_len (
    .icode      (icode),
    .ifun       (ifun),
    .legal      (legal),
    .has_regids (has_regids),
    .has_valc   (has_valc),
    .len        (len)
  );

  function automatic logic [7:0] pick_byte(
    input logic [3:0]  idx,
    input logic [3:0]  ic,
    input logic [3:0]  ifn,
    input logic [3:0]  ra,
    input logic [3:0]  rb,
    input logic [63:0] vc,
    input logic        regids
  );
    logic [3:0] vidx;
    logic [7:0] b;
    vidx = 4'd0;
    b    = 8'h00;
    if (idx == 4'd0) begin
      b = {ic, ifn};
    end else if (regids && (idx == 4'd1)) begin
      b = {ra, rb};
    end else begin
      // valC is little-endian, starting right after the header byte(s).
      vidx = regids ? (idx - 4'd2) : (idx - 4'd1);
      b    = vc[{vidx[2:0], 3'b000} +: 8];
    end
    return b;
  endfunction

  function automatic logic [ADDR_W-1:0] ext_addr(input logic [3:0] v);
    return {{(ADDR_W-4){1'b0}}, v};
  endfunction

  assign in_ready = (state == ST_IDLE) && !set_pc;
  assign accept   = in_valid && in_ready;
  assign idx_nxt  = idx_q + 4'd1;

  // Instruction fields captured at accept; held for the whole emission.
  always_ff @(posedge clk) begin
    if (accept && legal) begin
      icode_q      <= icode;
      ifun_q       <= ifun;
      ra_q         <= rA;
      rb_q         <= rB;
      valc_q       <= has_valc ? valC : 64'd0;
      len_q        <= len;
      has_regids_q <= has_regids;
    end
  end

  // Control FSM with registered byte-port outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= ST_IDLE;
      pc         <= START_ADDR;
      idx_q      <= 4'd0;
      byte_valid <= 1'b0;
      byte_last  <= 1'b0;
      byte_addr  <= '0;
      byte_data  <= 8'h00;
      enc_err    <= 1'b0;
    end else begin
      enc_err <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (set_pc) begin
            pc <= new_pc;
          end else if (accept) begin
            if (legal) begin
              state      <= ST_EMIT;
              idx_q      <= 4'd0;
              byte_valid <= 1'b1;
              byte_addr  <= pc;
              byte_data  <= {icode, ifun};
              byte_last  <= (len == 4'd1);
            end else begin
              enc_err <= 1'b1;
            end
          end
        end
        ST_EMIT: begin
          if (byte_ready) begin
            if (byte_last) begin
              pc         <= pc + ext_addr(len_q);
              state      <= ST_IDLE;
              byte_valid <= 1'b0;
              byte_last  <= 1'b0;
            end else begin
              idx_q      <= idx_nxt;
              byte_addr  <= pc + ext_addr(idx_nxt);
              byte_data  <= pick_byte(idx_nxt, icode_q, ifun_q, ra_q, rb_q, valc_q, has_regids_q);
              byte_last  <= (idx_nxt == (len_q - 4'd1));
            end
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_y86_instr_encoder.sv
// Directed bench for y86_instr_encoder: hand-computed byte streams, PC updates and error pulses.
module tb_y86_instr_encoder;

  logic        clk = 1'b0;
  logic        rst;
  logic        set_pc;
  logic [63:0] new_pc;
  logic        in_valid;
  logic        in_ready;
  logic [3:0]  icode;
  logic [3:0]  ifun;
  logic [3:0]  rA;
  logic [3:0]  rB;
  logic [63:0] valC;
  logic        byte_valid;
  logic        byte_ready;
  logic [63:0] byte_addr;
  logic [7:0]  byte_data;
  logic        byte_last;
  logic [63:0] pc;
  logic        enc_err;

  int checks = 0;
  int fails  = 0;

  y86_instr_encoder #(.ADDR_W(64), .START_ADDR(64'd0)) dut (
    .clk        (clk),
    .rst        (rst),
    .set_pc     (set_pc),
    .new_pc     (new_pc),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .icode      (icode),
    .ifun       (ifun),
    .rA         (rA),
    .rB         (rB),
    .valC       (valC),
    .byte_valid (byte_valid),
    .byte_ready (byte_ready),
    .byte_addr  (byte_addr),
    .byte_data  (byte_data),
    .byte_last  (byte_last),
    .pc         (pc),
    .enc_err    (enc_err)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic issue(input logic [3:0] ic, input logic [3:0] fn, input logic [3:0] a,
                       input logic [3:0] b, input logic [63:0] c);
    icode = ic; ifun = fn; rA = a; rB = b; valC = c;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
  endtask

  logic [7:0] irm_bytes [10];
  logic [7:0] call_bytes [9];

  initial begin
    irm_bytes  = '{8'h30, 8'hF2, 8'hEF, 8'hCD, 8'hAB, 8'h89, 8'h67, 8'h45, 8'h23, 8'h01};
    call_bytes = '{8'h80, 8'h40, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
    rst = 1'b1; set_pc = 1'b0; new_pc = '0; in_valid = 1'b0;
    icode = '0; ifun = '0; rA = '0; rB = '0; valC = '0; byte_ready = 1'b1;

    // Reset state
    tick(); tick();
    chk("rst_byte_valid", byte_valid, 1'b0);
    chk("rst_byte_last", byte_last, 1'b0);
    chk("rst_byte_addr", byte_addr, 64'd0);
    chk("rst_byte_data", byte_data, 8'h00);
    chk("rst_enc_err", enc_err, 1'b0);
    chk("rst_in_ready", in_ready, 1'b1);
    chk("rst_pc", pc, 64'd0);
    rst = 1'b0;

    // halt: single byte 00 @0
    issue(4'h0, 4'h0, 4'h0, 4'h0, 64'd0);
    chk("halt_valid", byte_valid, 1'b1);
    chk("halt_data", byte_data, 8'h00);
    chk("halt_addr", byte_addr, 64'd0);
    chk("halt_last", byte_last, 1'b1);
    chk("halt_busy", in_ready, 1'b0);
    tick();
    chk("halt_done_valid", byte_valid, 1'b0);
    chk("halt_pc", pc, 64'd1);

    // irmovq at 0x100
    set_pc = 1'b1; new_pc = 64'h100;
    tick();
    set_pc = 1'b0;
    chk("setpc_100", pc, 64'h100);
    issue(4'h3, 4'h0, 4'hF, 4'h2, 64'h0123456789ABCDEF);
    for (int i = 0; i < 10; i++) begin
      chk($sformatf("irm_valid%0d", i), byte_valid, 1'b1);
      chk($sformatf("irm_addr%0d", i), byte_addr, 64'h100 + 64'(i));
      chk($sformatf("irm_data%0d", i), byte_data, irm_bytes[i]);
      chk($sformatf("irm_last%0d", i), byte_last, (i == 9) ? 1'b1 : 1'b0);
      tick();
    end
    chk("irm_done_valid", byte_valid, 1'b0);
    chk("irm_pc", pc, 64'h10A);

    // call with stalls; set_pc held during emission must be ignored
    byte_ready = 1'b0;
    issue(4'h8, 4'h0, 4'h0, 4'h0, 64'h40);
    set_pc = 1'b1; new_pc = 64'hDEAD;
    for (int i = 0; i < 9; i++) begin
      byte_ready = 1'b0;
      chk($sformatf("call_valid%0d", i), byte_valid, 1'b1);
      chk($sformatf("call_addr%0d", i), byte_addr, 64'h10A + 64'(i));
      chk($sformatf("call_data%0d", i), byte_data, call_bytes[i]);
      chk($sformatf("call_last%0d", i), byte_last, (i == 8) ? 1'b1 : 1'b0);
      tick();
      chk($sformatf("call_stall_addr%0d", i), byte_addr, 64'h10A + 64'(i));
      chk($sformatf("call_stall_data%0d", i), byte_data, call_bytes[i]);
      chk($sformatf("call_stall_valid%0d", i), byte_valid, 1'b1);
      byte_ready = 1'b1;
      tick();
    end
    set_pc = 1'b0;
    chk("call_done_valid", byte_valid, 1'b0);
    chk("call_pc", pc, 64'h113);

    // Illegal: OPq ifun=4
    issue(4'h6, 4'h4, 4'h1, 4'h2, 64'd0);
    chk("opq4_err", enc_err, 1'b1);
    chk("opq4_no_byte", byte_valid, 1'b0);
    chk("opq4_ready", in_ready, 1'b1);
    chk("opq4_pc", pc, 64'h113);
    tick();
    chk("opq4_err_pulse", enc_err, 1'b0);
    chk("opq4_no_byte2", byte_valid, 1'b0);

    // Illegal: icode D
    issue(4'hD, 4'h0, 4'h0, 4'h0, 64'd0);
    chk("icD_err", enc_err, 1'b1);
    chk("icD_no_byte", byte_valid, 1'b0);
    chk("icD_pc", pc, 64'h113);
    tick();
    chk("icD_err_pulse", enc_err, 1'b0);

    // set_pc wins over in_valid
    set_pc = 1'b1; new_pc = 64'h200;
    icode = 4'h1; ifun = 4'h0; in_valid = 1'b1;
    #1;
    chk("setpc_in_ready", in_ready, 1'b0);
    tick();
    set_pc = 1'b0; in_valid = 1'b0;
    chk("setpc_200", pc, 64'h200);
    chk("setpc_no_byte", byte_valid, 1'b0);
    issue(4'h1, 4'h0, 4'h0, 4'h0, 64'd0);
    chk("nop_addr", byte_addr, 64'h200);
    chk("nop_data", byte_data, 8'h10);
    chk("nop_last", byte_last, 1'b1);
    tick();
    chk("nop_pc", pc, 64'h201);

    // pushq across the top of the address space
    set_pc = 1'b1; new_pc = 64'hFFFF_FFFF_FFFF_FFFF;
    tick();
    set_pc = 1'b0;
    issue(4'hA, 4'h0, 4'h3, 4'hF, 64'd0);
    chk("push_addr0", byte_addr, 64'hFFFF_FFFF_FFFF_FFFF);
    chk("push_data0", byte_data, 8'hA0);
    chk("push_last0", byte_last, 1'b0);
    tick();
    chk("push_addr1", byte_addr, 64'd0);
    chk("push_data1", byte_data, 8'h3F);
    chk("push_last1", byte_last, 1'b1);
    tick();
    chk("push_pc_wrap", pc, 64'd1);

    // rmmovq aborted by reset on byte 4
    issue(4'h4, 4'h0, 4'h1, 4'h2, 64'h1122334455667788);
    chk("rm_data0", byte_data, 8'h40);
    tick(); tick(); tick(); tick();
    chk("rm_addr4", byte_addr, 64'd5);
    chk("rm_data4", byte_data, 8'h66);
    chk("rm_valid4", byte_valid, 1'b1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("rm_rst_valid", byte_valid, 1'b0);
    chk("rm_rst_pc", pc, 64'd0);
    chk("rm_rst_ready", in_ready, 1'b1);
    tick();
    chk("rm_rst_stay_idle", byte_valid, 1'b0);

    $display("%0d/%0d checks passed", checks - fails, checks);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
